// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
//   Words are queued in a small FIFO through a valid/ready handshake. Each
//   word is sent LSB-first as one frame: a start bit, DATA_W data bits, an
//   optional even/odd parity bit, and 1 or 2 stop bits. Every bit lasts
//   CLKS_PER_BIT clocks.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_data, i_valid, o_ready       push side; a word is accepted when i_valid && o_ready
//   i_parity_en, i_parity_odd      parity insert / odd select, latched at frame start
//   i_stop2                        two stop bits, latched at frame start
//   o_data                         registered serial line, idle high
//   o_busy                         frame in progress or words still queued
//   o_level                        FIFO occupancy
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int CNT_W        = 8,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_stop2,
  output logic              o_data,
  output logic              o_busy,
  output logic [LVL_W-1:0]  o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]    BIT_LAST = BW'(DATA_W - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  // Frame registers
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_en;
  logic              par_bit;
  logic              stop2_q;
  logic              stop_idx;

  // A push while full is refused even if the FSM pops on the same edge,
  // because o_ready only looks at the registered level.
  assign o_ready  = (level != LVL_FULL);
  assign push     = i_valid && o_ready;
  assign pop      = (state == IDLE) && (level != '0);
  assign head     = mem[rd_ptr];
  assign o_level  = level;
  assign o_busy   = (state != IDLE) || (level != '0);
  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // o_data is registered and always reflects the bit of the current state;
  // each transition loads the value of the bit being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
      o_data   <= 1'b1;
    end else begin
      if (state != IDLE) begin
        cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          o_data <= 1'b1;
          cnt    <= '0;
          if (pop) begin
            shreg   <= head;
            par_en  <= i_parity_en;
            par_bit <= (^head) ^ i_parity_odd;
            stop2_q <= i_stop2;
            o_data  <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (cnt_last) begin
            o_data  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt_last) begin
            if (bit_idx == BIT_LAST) begin
              if (par_en) begin
                o_data <= par_bit;
                state  <= PARITY;
              end else begin
                o_data   <= 1'b1;
                stop_idx <= 1'b0;
                state    <= STOP;
              end
            end else begin
              o_data  <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        PARITY: begin
          if (cnt_last) begin
            o_data   <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          o_data <= 1'b1;
          if (cnt_last) begin
            if (stop2_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          o_data <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
